ram_stream_reader: RTL and testbench

//   Read-side controller for simple_dual_ram. Accepts a start_addr/count burst

---
 rtl/ram_stream_reader.sv | 134 +++++++++++++
 tb/tb_ram_stream_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Burst read controller for a 1-cycle-latency simple dual-port RAM.
// Issues reads for a start_addr/count command and presents the words as a valid/ready stream.
module ram_stream_reader #(
  parameter  int SIZE  = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   start_addr,
  input  logic [AW:0]     count,
  input  logic            abort,
  output logic [AW-1:0]   raddr,
  input  logic [SIZE-1:0] read_data,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  state_t          state_next;
  logic            done_next;
  logic [AW:0]     remaining;
  logic            inflight;
  logic [1:0]      buf_count;
  logic [SIZE-1:0] slot0;
  logic [SIZE-1:0] slot1;

  logic            pop;
  logic            issue;
  logic            flush;
  logic            accept_start;
  logic [2:0]      occupancy;
  logic [AW-1:0]   raddr_inc;

  assign out_valid    = (buf_count != 2'd0);
  assign out_data     = slot0;
  assign busy         = (state != IDLE);
  assign pop          = out_valid & out_ready;
  assign flush        = abort & (state != IDLE);
  assign accept_start = start & ~abort & (state == IDLE);
  // Words that will sit in the skid buffer after this edge, counting the read already in flight.
  assign occupancy    = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue        = (state == RUN) & (remaining != '0) & (occupancy <= 3'd1) & ~abort;
  assign raddr_inc    = (raddr == AW'(DEPTH - 1)) ? '0 : raddr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept_start) begin
          if (count == '0) done_next = 1'b1;
          else             state_next = RUN;
        end
      end
      RUN: begin
        if (abort)                                        state_next = IDLE;
        else if (issue && remaining == (AW + 1)'(1))      state_next = DRAIN;
      end
      DRAIN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (pop && buf_count == 2'd1 && !inflight) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr     <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      buf_count <= 2'd0;
      slot0     <= '0;
      slot1     <= '0;
    end else if (flush) begin
      // The pending RAM result is dropped by clearing inflight.
      remaining <= '0;
      inflight  <= 1'b0;
      buf_count <= 2'd0;
    end else begin
      if (accept_start) begin
        raddr     <= start_addr;
        remaining <= count;
      end else if (issue) begin
        raddr     <= raddr_inc;
        remaining <= remaining - 1'b1;
      end
      inflight <= issue;

      case ({inflight, pop})
        2'b10: begin
          if (buf_count == 2'd0) slot0 <= read_data;
          else                   slot1 <= read_data;
          buf_count <= buf_count + 2'd1;
        end
        2'b01: begin
          slot0     <= slot1;
          buf_count <= buf_count - 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            slot0 <= read_data;
          end else begin
            slot0 <= slot1;
            slot1 <= read_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM plus a queue of expected words per burst.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ram_stream_reader;
  localparam int SIZE  = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [AW-1:0]   start_addr;
  logic [AW:0]     count;
  logic            abort;
  logic [AW-1:0]   raddr;
  logic [SIZE-1:0] read_data;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;

  logic [SIZE-1:0] mem [DEPTH];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) read_data <= mem[raddr];

  ram_stream_reader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
    .abort(abort), .raddr(raddr), .read_data(read_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  // mode 0: ready always high; 1: random ready; 2: low 5 cycles then 1010...
  task automatic run_burst(input int sa, input int cnt, input int mode, input int abort_after,
                           input bit poke_start);
    logic [SIZE-1:0] exp_q[$];
    logic [SIZE-1:0] held;
    bit stall;
    bit last;
    int cyc;
    int got;
    exp_q = {};
    for (int i = 0; i < cnt; i++) exp_q.push_back(mem[(sa + i) % DEPTH]);
    start = 1'b1; start_addr = AW'(sa); count = (AW + 1)'(cnt); abort = 1'b0; out_ready = 1'b0;
    stall = 1'b0; last = (cnt == 0); cyc = 0; got = 0; held = '0;
    while (1) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; cyc++;
      if (last) begin
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL burst_end sa=%0d cnt=%0d: done=%b busy=%b valid=%b, required done=1 busy=0 valid=0",
                   sa, cnt, done, busy, out_valid);
        end
        break;
      end
      if (cyc > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL burst_timeout sa=%0d cnt=%0d: delivered %0d, required %0d", sa, cnt, got, cnt);
        break;
      end
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_busy sa=%0d cnt=%0d cyc=%0d: done=%b busy=%b, required done=0 busy=1",
                 sa, cnt, cyc, done, busy);
      end
      if (cyc <= 3) begin
        n_cmp++;
        if (out_valid !== (cyc == 3)) begin
          n_fail++;
          $display("FAIL first_latency cyc=%0d: valid=%b, required %b", cyc, out_valid, cyc == 3);
        end
      end
      if (stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d: valid=%b data=%h, required valid=1 data=%h",
                   cyc, out_valid, out_data, held);
        end
      end
      if (mode == 0 && cyc <= cnt) begin
        n_cmp++;
        if (raddr !== AW'((sa + cyc - 1) % DEPTH)) begin
          n_fail++;
          $display("FAIL raddr_seq cyc=%0d: raddr=%0d, required %0d", cyc, raddr, (sa + cyc - 1) % DEPTH);
        end
      end
      if (got == abort_after) begin
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_flush: valid=%b busy=%b done=%b, required all 0", out_valid, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          n_cmp++;
          if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet cyc=%0d: valid=%b done=%b busy=%b, required all 0",
                     i, out_valid, done, busy);
          end
        end
        $display("burst sa=%0d cnt=%0d aborted after %0d words", sa, cnt, got);
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = (cyc <= 5) ? 1'b0 : ((cyc % 2) == 0);
      endcase
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_word: data=%h, required no more words", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL word sa=%0d idx=%0d: data=%h, required %h", sa, got, out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          got++;
          if (exp_q.size() == 0) last = 1'b1;
        end
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      if (poke_start && cyc == 2) begin
        start = 1'b1; start_addr = AW'($urandom_range(0, DEPTH - 1)); count = (AW + 1)'($urandom_range(1, 15));
      end
    end
    $display("burst sa=%0d cnt=%0d mode=%0d delivered=%0d cycles=%0d", sa, cnt, mode, got, cyc);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || raddr !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b raddr=%0d data=%h, required all 0",
               out_valid, busy, done, raddr, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: valid=%b busy=%b done=%b, required all 0", out_valid, busy, done);
    end
    $display("reset released");
  endtask

  task automatic test_basic();
    run_burst(2, 4, 0, -1, 1'b0);
    @(negedge clk);
    run_burst(6, 5, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    run_burst(0, 4, 2, -1, 1'b0);
  endtask

  task automatic test_count_zero();
    @(negedge clk);
    run_burst(5, 0, 0, -1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_after: done=%b busy=%b valid=%b, required all 0", done, busy, out_valid);
    end
    run_burst(1, 6, 1, -1, 1'b1);
  endtask

  task automatic test_abort();
    @(negedge clk);
    run_burst(4, 8, 0, 2, 1'b0);
    start = 1'b1; abort = 1'b1; start_addr = 3'd3; count = 4'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_over_start cyc=%0d: busy=%b done=%b valid=%b, required all 0",
                 i, busy, done, out_valid);
      end
      @(negedge clk);
    end
    run_burst(0, 1, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    start = 1'b1; start_addr = 3'd1; count = 4'd6; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: valid=%b, required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || raddr !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b busy=%b done=%b raddr=%0d data=%h, required all 0",
               out_valid, busy, done, raddr, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle cyc=%0d: valid=%b busy=%b done=%b, required all 0",
                 i, out_valid, busy, done);
      end
    end
    $display("reset mid-burst checked");
  endtask

  task automatic test_back_to_back();
    run_burst(3, 3, 0, -1, 1'b0);
    run_burst(5, 4, 0, -1, 1'b0);
    run_burst(7, 2, 1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = SIZE'($urandom);
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) != 0) @(negedge clk);
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)), 1, -1,
                $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; start_addr = '0; count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = SIZE'(8'hA0 + i);
    test_reset();
    test_basic();
    test_backpressure();
    test_count_zero();
    test_abort();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
